// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: per-register countdown scoreboard, mult/div occupancy FSM, branch/jump redirect.
// Zero-cycle combinational stall/flush/pc_src; HAZARD_SCOREBOARD_STATS_EN adds saturating stall/flush counters.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_read,
  input  logic              id_rt_read,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              id_is_md,
  input  logic              jump,
  input  logic              ex_mem_branch,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [2:0]        pc_src,
  output logic              md_busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_events
`endif
);

  localparam int MAX_LAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MD_CNT   = CW'(MD_LAT);
  localparam logic [2:0] PC_SEQ    = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b001;
  localparam logic [2:0] PC_JUMP   = 3'b010;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  logic [CW-1:0] cnt [NUM_REGS];
  md_state_t     state, state_nxt;
  logic [CW-1:0] md_cnt, md_cnt_nxt;
  logic          pend_rs, pend_rt;
  logic          raw_hz, st_hz, stall, issue;

  // Indices >= NUM_REGS never match the loop, so they read as not pending.
  always_comb begin
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (id_rs == REG_AW'(r) && cnt[r] != '0) pend_rs = 1'b1;
      if (id_rt == REG_AW'(r) && cnt[r] != '0) pend_rt = 1'b1;
    end
  end

  assign md_busy = (state == MD_BUSY);
  assign raw_hz  = id_valid && ((id_rs_read && pend_rs) || (id_rt_read && pend_rt));
  assign st_hz   = id_valid && id_is_md && md_busy;
  assign stall   = (raw_hz || st_hz) && !ex_mem_branch;
  assign issue   = id_valid && !stall && !ex_mem_branch;

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_src       = PC_SEQ;
    if (rst_n) begin
      if (ex_mem_branch) begin
        pc_src       = PC_BRANCH;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (stall) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (jump) begin
        pc_src      = PC_JUMP;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Issue write takes precedence over the per-cycle countdown of the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r != 0 && issue && id_wr_en && id_rd == REG_AW'(r)) begin
          cnt[r] <= id_is_load ? LOAD_CNT : (id_is_md ? MD_CNT : '0);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      MD_IDLE: begin
        if (issue && id_is_md) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = CW'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0) state_nxt = MD_IDLE;
        else              md_cnt_nxt = md_cnt - CW'(1);
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall && stall_cycles != 16'hFFFF)         stall_cycles <= stall_cycles + 16'd1;
      if (ex_mem_branch && flush_events != 16'hFFFF) flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic against a ready-time model.
module tb_hazard_scoreboard;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 1;
  localparam int MD_LAT   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_rs_read, id_rt_read, id_wr_en, id_is_load, id_is_md, jump, ex_mem_branch;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
  logic [2:0] pc_src;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles, flush_events;
  int e_stall_cnt = 0, e_flush_cnt = 0;
`endif

  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_read(id_rs_read), .id_rt_read(id_rt_read), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .jump(jump), .ex_mem_branch(ex_mem_branch),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pc_src(pc_src), .md_busy(md_busy)
`ifdef HAZARD_SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // Model: a register is pending while the current cycle is earlier than its ready cycle.
  longint cyc = 0;
  longint ready_at [NUM_REGS];
  longint md_free_at = 0;
  bit e_stall, e_issue;
  logic obs_stall, obs_busy;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend(input logic [REG_AW-1:0] r);
    return (r != 0) && (int'(r) < NUM_REGS) && (cyc < ready_at[r]);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
    md_free_at = 0;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    e_stall_cnt = 0;
    e_flush_cnt = 0;
`endif
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit rsr, input bit rtr,
                       input bit wr, input int rd, input bit ld, input bit md, input bit jmp, input bit br);
    id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt); id_rs_read = rsr; id_rt_read = rtr;
    id_wr_en = wr; id_rd = REG_AW'(rd); id_is_load = ld; id_is_md = md; jump = jmp; ex_mem_branch = br;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc_stall"}, 16'(pc_stall), 16'd0);
    chk({tag, "_if_id_stall"}, 16'(if_id_stall), 16'd0);
    chk({tag, "_flushes"}, 16'({if_id_flush, id_ex_flush, ex_mem_flush}), 16'd0);
    chk({tag, "_pc_src"}, 16'(pc_src), 16'd0);
    chk({tag, "_md_busy"}, 16'(md_busy), 16'd0);
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag);
    bit busy, raw, st;
    logic [2:0] e_src;
    bit e_ifl, e_idx, e_exm;
    @(negedge clk);
    obs_stall = pc_stall;
    obs_busy  = md_busy;
    if (!rst_n) begin
      e_stall = 0; e_issue = 0;
      chk_zero({tag, "_rst"});
    end else begin
      busy    = (cyc < md_free_at);
      raw     = id_valid && ((id_rs_read && pend(id_rs)) || (id_rt_read && pend(id_rt)));
      st      = id_valid && id_is_md && busy;
      e_stall = (raw || st) && !ex_mem_branch;
      e_issue = id_valid && !e_stall && !ex_mem_branch;
      e_src = 3'b000; e_ifl = 0; e_idx = 0; e_exm = 0;
      if (ex_mem_branch) begin
        e_src = 3'b001; e_ifl = 1; e_idx = 1; e_exm = 1;
      end else if (e_stall) begin
        e_idx = 1;
      end else if (jump) begin
        e_src = 3'b010; e_idx = 1;
      end
      chk({tag, "_pc_stall"}, 16'(pc_stall), 16'(e_stall));
      chk({tag, "_if_id_stall"}, 16'(if_id_stall), 16'(e_stall));
      chk({tag, "_if_id_flush"}, 16'(if_id_flush), 16'(e_ifl));
      chk({tag, "_id_ex_flush"}, 16'(id_ex_flush), 16'(e_idx));
      chk({tag, "_ex_mem_flush"}, 16'(ex_mem_flush), 16'(e_exm));
      chk({tag, "_pc_src"}, 16'(pc_src), 16'(e_src));
      chk({tag, "_md_busy"}, 16'(md_busy), 16'(busy));
    end
    @(posedge clk);
    if (rst_n) begin
      if (e_issue && id_wr_en && id_rd != 0 && int'(id_rd) < NUM_REGS)
        ready_at[id_rd] = cyc + 1 + (id_is_load ? LOAD_LAT : (id_is_md ? MD_LAT : 0));
      if (e_issue && id_is_md) md_free_at = cyc + 1 + MD_LAT;
`ifdef HAZARD_SCOREBOARD_STATS_EN
      if (e_stall && e_stall_cnt < 65535) e_stall_cnt++;
      if (ex_mem_branch && e_flush_cnt < 65535) e_flush_cnt++;
`endif
    end
    cyc++;
    #1;
  endtask

  // Hold the current ID instruction until it issues; bounded so a stuck DUT still ends.
  task automatic until_issue(input string tag, output int nstall, output int nbusy);
    nstall = 0; nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      step(tag);
      if (obs_stall) nstall++;
      if (obs_busy) nbusy++;
      if (e_issue) break;
    end
    if (!e_issue) chk({tag, "_issue_timeout"}, 16'(e_issue), 16'd1);
  endtask

  int ns, nb;

  initial begin
    model_reset();
    drive(1, 5, 7, 1, 1, 1, 5, 1, 1, 1, 1);
    #3;
    chk_zero("reset");
    #9 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle");

    // Load-use
    drive(1, 1, 2, 1, 1, 1, 5, 1, 0, 0, 0); step("ld_r5");
    drive(1, 5, 0, 1, 0, 1, 6, 0, 0, 0, 0); until_issue("ld_use", ns, nb);
    chk("ld_use_stalls", 16'(ns), 16'(LOAD_LAT));

    // Mult/div result latency
    drive(1, 1, 2, 1, 1, 1, 7, 0, 1, 0, 0); step("md_r7");
    drive(1, 0, 7, 0, 1, 1, 9, 0, 0, 0, 0); until_issue("md_use", ns, nb);
    chk("md_use_stalls", 16'(ns), 16'(MD_LAT));
    chk("md_busy_cycles", 16'(nb), 16'(MD_LAT));

    // Structural hazard: second mult two cycles after the first
    drive(1, 1, 2, 1, 1, 1, 8, 0, 1, 0, 0); step("md1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("md_gap");
    drive(1, 3, 4, 1, 1, 1, 10, 0, 1, 0, 0); until_issue("md2", ns, nb);
    chk("md_struct_stalls", 16'(ns), 16'(MD_LAT - 1));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (MD_LAT + 2) step("drain");

    // Branch overrides stall and suppresses the scoreboard write
    drive(1, 1, 2, 1, 1, 1, 4, 1, 0, 0, 0); step("ld_r4");
    drive(1, 4, 0, 1, 0, 1, 6, 0, 1, 0, 1); step("br_ovr");
    chk("br_ovr_pc_stall", 16'(obs_stall), 16'd0);
    drive(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0); step("br_no_sb");
    chk("br_no_sb_stall", 16'(obs_stall), 16'd0);
    chk("br_no_md_busy", 16'(obs_busy), 16'd0);

    // Jump waits behind a stall
    drive(1, 1, 2, 1, 1, 1, 2, 1, 0, 0, 0); step("ld_r2");
    drive(1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0); step("jmp_stall");
    step("jmp_go");

    // r0 and unused source
    drive(1, 1, 2, 1, 1, 1, 0, 1, 0, 0, 0); step("ld_r0");
    drive(1, 0, 0, 1, 1, 1, 11, 0, 0, 0, 0); step("rd_r0");
    chk("r0_no_stall", 16'(obs_stall), 16'd0);
    drive(1, 1, 2, 1, 1, 1, 3, 1, 0, 0, 0); step("ld_r3");
    drive(1, 1, 3, 1, 0, 1, 12, 0, 0, 0, 0); step("rt_unused");
    chk("rt_unused_no_stall", 16'(obs_stall), 16'd0);

    // Reset during an md stall
    drive(1, 1, 2, 1, 1, 1, 7, 0, 1, 0, 0); step("md_r7b");
    drive(1, 7, 0, 1, 0, 1, 13, 0, 0, 0, 0);
    repeat (3) step("md_wait");
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_reset();
    step("rst_hold");
    #2 rst_n = 1'b1;
    step("rst_after");
    chk("rst_after_no_stall", 16'(obs_stall), 16'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      step("rnd");
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    #1;
    chk("stall_cycles", stall_cycles, 16'(e_stall_cnt));
    chk("flush_events", flush_events, 16'(e_flush_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
